data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer in front of `Data_Memory`, the 64-byte, byte-addressed, little-endian doubleword store. It shares the memory between the core load/store port (port 0) and a loader/debug port (port 1) using round-robin arbitration. Each access is sequenced through a fixed three-state FSM, every request is checked for alignment and range, and each port receives a registered one-cycle response. The block sits between the datapath/loader and `Data_Memory`, and owns that memory's `Mem_Addr`, `Write_Data`, `MemWrite` and `MemRead` inputs.

## Interface
- `MEM_BYTES`, 64, memory size in bytes; must be a multiple of 8
- `ADDR_W`, 64, requester and memory address width
- `DATA_W`, 64, data width; fixed at 8 bytes per access

Ports (`p` = 0, 1):
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_p`  in  1  request; held with `we_p`, `addr_p` and `wdata_p` until `ack_p`
- `we_p`  in  1  1 = store doubleword, 0 = load doubleword
- `addr_p`  in  ADDR_W  byte address
- `wdata_p`  in  DATA_W  store data
- `gnt_p`  out  1  high while port p owns the memory (ACCESS and RESP states)
- `ack_p`  out  1  one-cycle completion pulse
- `rdata_p`  out  DATA_W  registered load data, valid with `ack_p`
- `err_p`  out  1  valid with `ack_p`; signals a misaligned or out-of-range access
- `Mem_Addr`  out  ADDR_W  to memory
- `Write_Data`  out  DATA_W  to memory
- `MemWrite`  out  1  to memory; the memory commits on the rising edge of `clk`
- `MemRead`  out  1  to memory
- `Read_Data`  in  DATA_W  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any `req_p` is high, pick a winner, latch `owner`, and go to ACCESS. With no requests, stay in IDLE.
- **Arbitration:** round-robin driven by `last` (reset value 1, so port 0 wins the first tie).
  - Both ports requesting: grant goes to `!last`.
  - One port requesting: that port wins.
  - `last` updates to the winner only when a grant is issued.
- **ACCESS:** drive the memory from the owner's inputs.
  - `Mem_Addr = addr_owner`, `Write_Data = wdata_owner`.
  - `MemWrite = we & ok`, `MemRead = !we & ok`.
  - `ok` = (`addr[2:0] == 0`) && (`addr <= MEM_BYTES-8`), with the compare done at full ADDR_W and no truncation.
  - At the edge ending ACCESS: capture `Read_Data` into `rdata_owner` if this is a load and `ok`; otherwise capture 0. Capture `!ok` into `err_owner`. Go to RESP.
- **RESP:** `ack_owner = 1` for exactly one cycle; then return to IDLE.
  - The non-owner's `ack`, `rdata` and `err` stay 0, because responses are steered to the owner only.
- **Held rdata/err:** `rdata_p` and `err_p` keep their values until that port's next RESP. They are meaningful only when `ack_p` is high.
- **Error requests:** a request that fails `ok` takes the full three-state path. Both memory strobes stay 0 throughout, so memory contents never change.
- **Memory idle:** outside ACCESS, `MemWrite = MemRead = 0` and `Mem_Addr`/`Write_Data` are driven 0.
- **`gnt_p`:** equals (state ≠ IDLE) && (`owner == p`).
- **Request dropped early:** dropping `req_p` before `ack_p` is a protocol violation. The arbiter still completes the transaction.
- **Reset:** forces IDLE asynchronously.
  - All outputs go to 0: `gnt`, `ack`, `err`, `rdata`, memory strobes and buses.
  - `last` goes to 1.
  - Because `MemWrite` is decoded from state, reset during ACCESS suppresses the write at the next edge.

## Timing
- **Latency:** `req_p` sampled high at edge 0 → ACCESS during cycle 1 → `ack_p` high during cycle 2 → IDLE during cycle 3.
- **Throughput:** one access per 3 cycles; there is no back-to-back overlap.
- **Store visibility:** the store commits at the edge ending ACCESS. A load issued afterwards by either port sees the new data.
- **Fairness:** with both ports continuously requesting, grants alternate 0,1,0,1… Each port waits at most 3 cycles beyond its own transaction.
- **Re-request:** a port may keep `req_p` high through `ack_p` to issue its next request. That request is evaluated in the following IDLE cycle.
- **Combinational paths:**
  - `Read_Data` reaches only the capture register.
  - Memory-side outputs are decoded from registered state and the owner's input mux.
  - No combinational path from `req_p` to any output.

## Structure
- **Package `data_mem_pkg`:**
  - state encoding (IDLE=0, ACCESS=1, RESP=2)
  - `MEM_BYTES` default
  - function `dw_access_ok(addr)` implementing the alignment and range check
- **Sub-module `mem_rr_pick`:** combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `winner`.
  - Instantiated once.
- **Top level:** FSM, owner mux, capture registers and response registers.

## Test plan
- Reset, then port 0 stores 64'h1122334455667788 at addr 8; port 0 then loads addr 8 → `rdata_0` = 64'h1122334455667788 with `ack_0` in the third cycle after each request, `err_0` = 0.
- Memory preloaded with 5, 6, 2, 3, 4 at addrs 0/8/16/24/32; port 1 loads addr 16 → `rdata_1` = 2; port 0 loads addr 32 → 4.
- Both ports request continuously from reset → grant order 0,1,0,1; each `ack` is exactly one cycle; `gnt_0` and `gnt_1` are never both high.
- Port 1 stores to addr 12 (misaligned), then addr 64 (out of range) → `err_1` = 1 with `ack_1` each time, `MemWrite` never asserts, and a load of addr 8 still returns its prior value.
- `reset` asserted low mid-ACCESS of a store of 64'hFF to addr 0 → `MemWrite` drops immediately, all outputs go to 0, and a load of addr 0 after release returns 5.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter:
// FSM encoding, memory size default and the access check.
package data_mem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Doubleword aligned and the whole doubleword fits in memory.
  function automatic logic dw_access_ok(
    input logic [63:0] addr,
    input int unsigned mem_bytes
  );
    logic [63:0] lim;
    lim = 64'(mem_bytes) - 64'd8;
    return (addr[2:0] == 3'b000) && (addr <= lim);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker: on a tie the port that
// did not win last time gets the grant.
module mem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/RESP sequencer
// sharing Data_Memory between the core and loader ports.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              ack_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              err_0,
  output logic              gnt_1,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              err_1,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0] err_q, err_d;

  logic pick_valid;
  logic pick_winner;
  logic own_we;
  logic own_ok;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  mem_rr_pick u_pick (
    .req    ({req_1, req_0}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign own_we    = owner_q ? we_1 : we_0;
  assign own_addr  = owner_q ? addr_1 : addr_0;
  assign own_wdata = owner_q ? wdata_1 : wdata_0;
  assign own_ok    = dw_access_ok(64'(own_addr), MEM_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          owner_d = pick_winner;
          last_d  = pick_winner;
        end
      end
      ST_ACCESS: begin
        rdata_d[owner_q] = (!own_we && own_ok)
                         ? Read_Data : '0;
        err_d[owner_q]   = ~own_ok;
        state_d          = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Mem_Addr   = '0;
    Write_Data = '0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    if (state_q == ST_ACCESS) begin
      Mem_Addr   = own_addr;
      Write_Data = own_wdata;
      MemWrite   = own_we & own_ok;
      MemRead    = ~own_we & own_ok;
    end
  end

  // Responses are steered to the owner only.
  assign gnt_0 = (state_q != ST_IDLE) && !owner_q;
  assign gnt_1 = (state_q != ST_IDLE) && owner_q;
  assign ack_0 = (state_q == ST_RESP) && !owner_q;
  assign ack_1 = (state_q == ST_RESP) && owner_q;

  assign rdata_0 = rdata_q[0];
  assign rdata_1 = rdata_q[1];
  assign err_0   = err_q[0];
  assign err_1   = err_q[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a
// behavioural memory and a transaction-level model.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req = '0;
  logic r_we [2];
  logic [63:0] r_addr [2];
  logic [63:0] r_wd [2];
  logic gnt_0, ack_0, err_0, gnt_1, ack_1, err_1;
  logic [63:0] rdata_0, rdata_1;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic MemWrite, MemRead;

  int n_checks = 0;
  int n_fail = 0;
  int bad_wr = 0;

  logic [63:0] dmem [8];
  logic [63:0] ref_mem [8];
  bit last_m;
  logic [63:0] got_rd [2];
  logic got_err [2];

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] erd;
    bit          eerr;
  } vec_t;
  vec_t tab [16];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_0      (req[0]),
    .we_0       (r_we[0]),
    .addr_0     (r_addr[0]),
    .wdata_0    (r_wd[0]),
    .req_1      (req[1]),
    .we_1       (r_we[1]),
    .addr_1     (r_addr[1]),
    .wdata_1    (r_wd[1]),
    .gnt_0      (gnt_0),
    .ack_0      (ack_0),
    .rdata_0    (rdata_0),
    .err_0      (err_0),
    .gnt_1      (gnt_1),
    .ack_1      (ack_1),
    .rdata_1    (rdata_1),
    .err_1      (err_1),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data)
  );

  assign Read_Data = dmem[Mem_Addr[5:3]];

  function automatic bit m_ok(input logic [63:0] a);
    return (a % 64'd8 == 64'd0) && (a < 64'd64);
  endfunction

  always @(posedge clk) begin
    if (MemWrite) dmem[Mem_Addr[5:3]] <= Write_Data;
    if (MemWrite && !m_ok(Mem_Addr)) bad_wr++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Issue the pending requests in mask and check each
  // response against the model as it arrives.
  task automatic run(input logic [1:0] mask);
    logic [1:0] pend;
    int cyc;
    bit first;
    bit expw;
    bit ok;
    logic [63:0] erd;
    logic [63:0] rd;
    logic er;
    pend  = mask;
    first = 1'b1;
    expw  = (mask == 2'b11) ? ~last_m : mask[1];
    req   = mask;
    cyc   = 0;
    while (pend != 2'b00 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      chk("gnt_excl", 64'(gnt_0 & gnt_1), 64'd0);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack_0 : ack_1) begin
          rd = (p == 0) ? rdata_0 : rdata_1;
          er = (p == 0) ? err_0 : err_1;
          chk("spurious_ack", 64'(pend[p]), 64'd1);
          if (pend[p]) begin
            if (first) begin
              chk("winner", 64'(p), 64'(expw));
              chk("latency", 64'(cyc), 64'd2);
              first = 1'b0;
            end
            ok  = m_ok(r_addr[p]);
            erd = '0;
            if (ok && !r_we[p])
              erd = ref_mem[int'(r_addr[p] / 64'd8)];
            chk("rdata", rd, erd);
            chk("err", 64'(er), 64'(!ok));
            if (ok && r_we[p])
              ref_mem[int'(r_addr[p] / 64'd8)] = r_wd[p];
            last_m    = p[0];
            got_rd[p] = rd;
            got_err[p] = er;
            pend[p] = 1'b0;
            req[p]  = 1'b0;
          end
        end
      end
    end
    if (pend != 2'b00) chk("timeout", 64'(pend), 64'd0);
    req = '0;
    @(negedge clk);
  endtask

  function automatic vec_t mk(bit p, bit we,
                              logic [63:0] a,
                              logic [63:0] wd,
                              logic [63:0] erd, bit ee);
    vec_t v;
    v.port = p; v.we = we; v.addr = a;
    v.wd = wd; v.erd = erd; v.eerr = ee;
    return v;
  endfunction

  function automatic logic [63:0] rnd_addr();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: return 64'($urandom_range(0, 7) * 8);
      1: return 64'($urandom_range(0, 7) * 8
                    + $urandom_range(1, 7));
      2: return 64'(64 + $urandom_range(0, 15) * 8);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int q_port [$];
    int q_cyc [$];
    logic [63:0] big;
    big = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 8; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0;
      got_rd[i] = '0; got_err[i] = 1'b0;
    end
    last_m = 1'b1;

    tab[0]  = mk(0, 1, 8,  64'h1122334455667788, 0, 0);
    tab[1]  = mk(0, 0, 8,  0, 64'h1122334455667788, 0);
    tab[2]  = mk(0, 1, 0,  5, 0, 0);
    tab[3]  = mk(1, 1, 8,  6, 0, 0);
    tab[4]  = mk(0, 1, 16, 2, 0, 0);
    tab[5]  = mk(1, 1, 24, 3, 0, 0);
    tab[6]  = mk(0, 1, 32, 4, 0, 0);
    tab[7]  = mk(1, 0, 16, 0, 2, 0);
    tab[8]  = mk(0, 0, 32, 0, 4, 0);
    tab[9]  = mk(1, 1, 12, 64'hAAAA, 0, 1);
    tab[10] = mk(1, 1, 64, 64'hBBBB, 0, 1);
    tab[11] = mk(1, 0, 8,  0, 6, 0);
    tab[12] = mk(1, 0, 56, 0, 0, 0);
    tab[13] = mk(0, 0, 57, 0, 0, 1);
    tab[14] = mk(0, 0, big, 0, 0, 1);
    tab[15] = mk(0, 0, 0,  0, 5, 0);

    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'({gnt_0, gnt_1}), 64'd0);
    chk("rst_ack", 64'({ack_0, ack_1}), 64'd0);
    chk("rst_err", 64'({err_0, err_1}), 64'd0);
    chk("rst_rdata0", rdata_0, 64'd0);
    chk("rst_strobes", 64'({MemWrite, MemRead}), 64'd0);
    chk("rst_addr", Mem_Addr, 64'd0);
    reset = 1'b1;

    // Both ports request continuously from reset.
    r_addr[0] = 64'd0;
    r_addr[1] = 64'd8;
    req = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("rr_gnt_excl", 64'(gnt_0 & gnt_1), 64'd0);
      chk("rr_ack_excl", 64'(ack_0 & ack_1), 64'd0);
      if (ack_0) begin q_port.push_back(0); q_cyc.push_back(c); end
      if (ack_1) begin q_port.push_back(1); q_cyc.push_back(c); end
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("rr_count", 64'(q_port.size()), 64'd4);
    for (int k = 0; k < q_port.size() && k < 4; k++) begin
      chk("rr_order", 64'(q_port[k]), 64'(k % 2));
      chk("rr_time", 64'(q_cyc[k]), 64'(2 + 3 * k));
    end
    last_m = 1'b1;

    for (int i = 0; i < 16; i++) begin
      r_we[tab[i].port]   = tab[i].we;
      r_addr[tab[i].port] = tab[i].addr;
      r_wd[tab[i].port]   = tab[i].wd;
      run(tab[i].port ? 2'b10 : 2'b01);
      chk("tab_rdata", got_rd[tab[i].port], tab[i].erd);
      chk("tab_err", 64'(got_err[tab[i].port]),
          64'(tab[i].eerr));
    end

    // Reset in the middle of a store to address 0.
    r_we[0] = 1'b1; r_addr[0] = '0; r_wd[0] = 64'hFF;
    req = 2'b01;
    @(negedge clk);
    chk("mid_we_pre", 64'(MemWrite), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_we_post", 64'(MemWrite), 64'd0);
    chk("mid_gnt", 64'({gnt_0, gnt_1}), 64'd0);
    chk("mid_bus", Mem_Addr | Write_Data, 64'd0);
    chk("mid_rdata0", rdata_0, 64'd0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_m = 1'b1;
    @(negedge clk);
    r_we[0] = 1'b0; r_addr[0] = '0;
    run(2'b01);
    chk("post_rst_load", got_rd[0], 64'd5);

    for (int it = 0; it < 80; it++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        r_we[p]   = 1'($urandom_range(0, 1));
        r_addr[p] = rnd_addr();
        r_wd[p]   = {$urandom, $urandom};
      end
      run(m);
    end

    chk("illegal_write", 64'(bad_wr), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
